// File: rtl/leiwand_lsu.sv
// Load/store initiator: one core access at a time onto a word-wide valid/ready bus,
// with lane steering, load extension, misalignment and timeout errors.
module leiwand_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        valid,
    input  logic        ready,
    output logic [3:0]  wen,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q, uns_q;
    logic [1:0]    size_q, off_q;
    logic          valid_q;
    logic [3:0]    wen_q;
    logic [31:0]   addr_q, wdata_q;
    logic          resp_valid_q, resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic          bad_d;
    logic [3:0]    wen_d;
    logic [31:0]   wdata_d;
    logic [7:0]    byte_d;
    logic [15:0]   half_d;
    logic [31:0]   load_d;

    always_comb begin
        bad_d = (req_size == 2'd3) ||
                (req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && req_addr[1:0] != 2'b00);
        wen_d   = '0;
        wdata_d = req_wdata;
        case (req_size)
            2'd0: begin
                wen_d   = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                wen_d   = 4'b0011 << req_addr[1:0];
                wdata_d = {2{req_wdata[15:0]}};
            end
            2'd2:    wen_d = 4'hF;
            default: wen_d = '0;
        endcase
        if (!req_we) wen_d = '0;
    end

    // Halfword offsets are 0 or 2 once alignment is checked, so off_q[1] picks the half.
    always_comb begin
        byte_d = rdata[{off_q, 3'b000} +: 8];
        half_d = off_q[1] ? rdata[31:16] : rdata[15:0];
        case (size_q)
            2'd0:    load_d = uns_q ? {24'h0, byte_d} : {{24{byte_d[7]}}, byte_d};
            2'd1:    load_d = uns_q ? {16'h0, half_d} : {{16{half_d[15]}}, half_d};
            default: load_d = rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            valid_q      <= 1'b0;
            wen_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        addr_q  <= {req_addr[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        if (bad_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q <= REQ;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            wen_q   <= wen_d;
                        end
                    end
                end
                REQ: begin
                    // ready wins over the timeout in the final counted cycle.
                    if (ready) begin
                        state_q      <= RESP;
                        valid_q      <= 1'b0;
                        wen_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : load_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= RESP;
                        valid_q      <= 1'b0;
                        wen_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign valid      = valid_q;
    assign wen        = wen_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/leiwand_lsu.md
# leiwand_lsu

Load/store initiator for the core's data port. It accepts one byte, halfword or word access at a time from the execute stage and runs the matching valid/ready transaction on the word-wide memory bus that the on-chip memory responds to. It handles byte-lane steering, sign/zero extension of loads, misalignment detection and a bus timeout, and returns exactly one response per request.

## Interface
- TIMEOUT, 16: bus cycles with valid high and no ready before the access is aborted with an error; legal range 2..255.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request strobe; sampled only while req_ready=1.
- req_ready  output  1  high exactly in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error).
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse; no back-pressure.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, reserved size, or timeout.
- valid  output  1  bus request.
- ready  input  1  bus response; rdata is valid in the same cycle.
- wen  output  4  byte write enables.
- addr  output  32  bus address, always {req_addr[31:2],2'b00}.
- wdata  output  32  lane-replicated store data.
- rdata  input  32  bus read data.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: req_ready=1. A request is accepted on the edge where req_valid=1. The block registers we/size/unsigned/addr[1:0]/wdata.
  - Misaligned or reserved request (half with addr[0]=1, word with addr[1:0]!=0, size=3): go to RESP with err=1. No bus activity.
  - Otherwise: go to REQ and clear the timeout counter.
- REQ: valid=1; addr, wen and wdata are stable throughout.
  - ready=1: capture the steered load data, then go to RESP with err=0.
  - ready=0: increment the counter. When the counter reaches TIMEOUT-1 with ready=0, go to RESP with err=1.
- RESP: resp_valid=1 together with the registered resp_rdata and resp_err. Next state is always IDLE. valid=0 and wen=0.
- Store lanes, with o = addr[1:0]:
  - Byte: wen = 4'b0001<<o; wdata = byte replicated ×4.
  - Half: wen = 4'b0011<<o; wdata = half replicated ×2.
  - Word: wen = 4'hF; wdata = req_wdata.
- Load extraction:
  - Byte: rdata[8*o+7 -: 8].
  - Half: rdata[8*o+15 -: 16].
  - Word: rdata.
  - Byte and half results are extended per req_unsigned.
- wen is 0 whenever valid=0. The responder writes on every edge wen is set, so a repeat write of identical data during REQ is allowed.
- ready is ignored outside REQ.

## Timing
- Reset values, forced asynchronously while rst_n=0, including mid-transaction:
  - state=IDLE, req_ready=1.
  - valid=0, wen=0, addr=0, wdata=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - The timeout counter is cleared.
- Against a one-cycle responder, for a request accepted at edge E0:
  - valid is high during cycles 1–2.
  - ready is seen in cycle 2.
  - resp_valid is high in cycle 3.
  - req_ready is high again in cycle 4.
- Error latency: accepted at E0, resp_valid in cycle 1.
- Timeout: valid is high for exactly TIMEOUT cycles, and resp_valid follows in the next cycle.
- RESP guarantees at least one cycle with valid=0 between transactions. This keeps a stale registered ready from the responder from completing the next access.
- The counter is ceil(log2(TIMEOUT)) bits wide and does not wrap before the limit.
- ready arriving in the final timeout cycle takes priority: the access completes with err=0.

## Test plan
- SW 0x20400004, data 0xDEADBEEF -> wen=4'hF, addr=0x20400004, resp_valid in cycle 3, resp_err=0, resp_rdata=0.
- Loads from the stored word:
  - LB 0x20400007 -> 0xFFFFFFDE.
  - LBU 0x20400007 -> 0x000000DE.
  - LH 0x20400006 -> 0xFFFFDEAD.
  - LHU 0x20400004 -> 0x0000BEEF.
- SB 0x20400005, data 0x12 -> wen=4'b0010, wdata=0x12121212; a following LW 0x20400004 -> 0xDEAD12EF.
- Error cases: LW 0x20400002 and SH 0x20400001 -> resp_err=1 in cycle 1, valid and wen never high. size=3 -> same response.
- LW 0x10000000 (no responder ready), TIMEOUT=16 -> valid high for exactly 16 cycles, resp_valid with err=1 in cycle 17, resp_rdata=0.
- rst_n pulsed low during REQ -> valid, wen and resp_valid drop immediately without a clock edge. After release req_ready=1, and no stale response pulse appears.
